// File: rtl/bcd_timer_ctrl_if.sv
// Command, status and counter-side signals of the BCD timer controller.
// master = user/counter side, slave = the controller.
interface bcd_timer_ctrl_if;
  logic       start, pause, clear, mode_up;
  logic [3:0] preset_0, preset_1, limit_0, limit_1;
  logic [3:0] cnt_0, cnt_1;
  logic       ctr_load, ctr_reset, ctr_count_up, ctr_on;
  logic [3:0] ctr_data_0, ctr_data_1;
  logic       busy, done;
  logic [2:0] state;

  modport master (
    output start, pause, clear, mode_up, preset_0, preset_1, limit_0, limit_1, cnt_0, cnt_1,
    input  ctr_load, ctr_reset, ctr_count_up, ctr_on, ctr_data_0, ctr_data_1, busy, done, state
  );

  modport slave (
    input  start, pause, clear, mode_up, preset_0, preset_1, limit_0, limit_1, cnt_0, cnt_1,
    output ctr_load, ctr_reset, ctr_count_up, ctr_on, ctr_data_0, ctr_data_1, busy, done, state
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Sequencer turning a two-digit BCD up/down counter into a countdown timer or stopwatch.
// Optional: define BCD_TIMER_AUTORELOAD_EN for a periodic timer (DONE reloads automatically).
module bcd_timer_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int PW       = 16
) (
  input  logic             clk,
  input  logic             reset,
  bcd_timer_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic          mode_q;
  logic [3:0]    data0_q, data1_q;
  logic          ctr_load_q, busy_q, done_q;
  logic          at_target, tick, start_cmd, latch_en;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Limit is compared live; a non-BCD limit digit simply never matches.
  assign at_target = mode_q ? ((bus.cnt_0 == bus.limit_0) && (bus.cnt_1 == bus.limit_1))
                            : ((bus.cnt_0 == 4'd0) && (bus.cnt_1 == 4'd0));
  assign tick      = (presc_q == TICK_LAST);
  assign start_cmd = bus.start && !bus.pause && !bus.clear;

`ifdef BCD_TIMER_AUTORELOAD_EN
  assign latch_en = (state_q == IDLE) && start_cmd;
`else
  assign latch_en = ((state_q == IDLE) || (state_q == DONE)) && start_cmd;
`endif

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (start_cmd) state_d = LOAD;
        LOAD:   state_d = RUN;
        RUN: begin
          if (at_target)      state_d = DONE;
          else if (bus.pause) state_d = PAUSED;
        end
        PAUSED: if (start_cmd) state_d = RUN;
`ifdef BCD_TIMER_AUTORELOAD_EN
        DONE:   state_d = LOAD;
`else
        DONE:   if (start_cmd) state_d = LOAD;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      mode_q     <= 1'b0;
      data0_q    <= 4'd0;
      data1_q    <= 4'd0;
      ctr_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_load_q <= (state_d == LOAD);
      busy_q     <= (state_d == LOAD) || (state_d == RUN) || (state_d == PAUSED);
      done_q     <= (state_d == DONE);
      if (latch_en) begin
        mode_q  <= bus.mode_up;
        data0_q <= bus.mode_up ? 4'd0 : clamp9(bus.preset_0);
        data1_q <= bus.mode_up ? 4'd0 : clamp9(bus.preset_1);
      end
      // Prescaler freezes while pausing so a resume keeps the tick phase.
      if (state_q == LOAD)
        presc_q <= '0;
      else if ((state_q == RUN) && !bus.pause && !bus.clear)
        presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  assign bus.ctr_on       = (state_q == RUN) && tick && !at_target && !bus.pause && !bus.clear;
  assign bus.ctr_reset    = reset || bus.clear;
  assign bus.ctr_load     = ctr_load_q;
  assign bus.ctr_count_up = mode_q;
  assign bus.ctr_data_0   = data0_q;
  assign bus.ctr_data_1   = data1_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: ideal BCD counter model, ctr_on timing scoreboard,
// table of full runs plus hand sequences for pause, priority, wrap, reset and DONE handling.
module tb_bcd_timer_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   exp_on[$];
  logic [7:0] cnt = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_timer_ctrl_if bus();
  bcd_timer_ctrl #(.TICK_DIV(4), .PW(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] u, t;
    u = v[3:0]; t = v[7:4];
    if (u == 4'd9) begin u = 4'd0; t = (t == 4'd9) ? 4'd0 : t + 4'd1; end
    else u = u + 4'd1;
    return {t, u};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] u, t;
    u = v[3:0]; t = v[7:4];
    if (u == 4'd0) begin u = 4'd9; t = (t == 4'd0) ? 4'd9 : t - 4'd1; end
    else u = u - 4'd1;
    return {t, u};
  endfunction

  // Ideal counter: everything acts on the edge, result visible next cycle.
  always @(posedge clk) begin
    if (bus.ctr_reset === 1'b1)     cnt <= 8'h00;
    else if (bus.ctr_load === 1'b1) cnt <= {bus.ctr_data_1, bus.ctr_data_0};
    else if (bus.ctr_on === 1'b1)   cnt <= bus.ctr_count_up ? bcd_inc(cnt) : bcd_dec(cnt);
  end
  assign bus.cnt_0 = cnt[3:0];
  assign bus.cnt_1 = cnt[7:4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Every ctr_on pulse must match the next expected tick cycle.
  always @(negedge clk) begin
    int e;
    #2;
    if (bus.ctr_on === 1'b1) begin
      if (exp_on.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected ctr_on: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = exp_on.pop_front();
        check("ctr_on cycle", cyc, e);
      end
    end
  end

  typedef struct {
    logic       mode;
    logic [3:0] p1, p0, l1, l0;
    logic [7:0] data;
    int         n;
    logic [7:0] fin;
  } vec_t;
  localparam int NV = 8;
  vec_t tbl[NV];

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk); bus.clear = 1'b1;
    @(negedge clk); bus.clear = 1'b0;
  endtask

  // Returns at the negedge of t1; inputs are scrambled after start to prove they were latched.
  task automatic issue_start(input logic m, input logic [3:0] p1, p0, l1, l0, output int t0);
    @(negedge clk);
    bus.mode_up = m; bus.preset_1 = p1; bus.preset_0 = p0;
    bus.limit_1 = l1; bus.limit_0 = l0; bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0; bus.mode_up = ~m; bus.preset_1 = 4'h0; bus.preset_0 = 4'h0;
  endtask

  task automatic wait_done(input int limit, output int at);
    while (bus.done !== 1'b1 && cyc < limit) begin @(negedge clk); #1; end
    at = cyc;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int t0, at;
    do_clear();
    issue_start(v.mode, v.p1, v.p0, v.l1, v.l0, t0);
    for (int k = 1; k <= v.n; k++) exp_on.push_back(t0 + 1 + 4 * k);
    #1;
    check($sformatf("v%0d ctr_load", i), bus.ctr_load, 1);
    check($sformatf("v%0d ctr_data", i), {bus.ctr_data_1, bus.ctr_data_0}, v.data);
    check($sformatf("v%0d count_up", i), bus.ctr_count_up, v.mode);
    check($sformatf("v%0d busy", i), bus.busy, 1);
    wait_done(t0 + 3 + 4 * v.n + 20, at);
    check($sformatf("v%0d done cycle", i), at, t0 + 3 + 4 * v.n);
    check($sformatf("v%0d final cnt", i), cnt, v.fin);
    check($sformatf("v%0d state", i), bus.state, 4);
    check($sformatf("v%0d busy at done", i), bus.busy, 0);
    check($sformatf("v%0d ticks left", i), exp_on.size(), 0);
  endtask

  initial begin
    int t0, at;
    bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.mode_up = 1'b0;
    bus.preset_0 = 4'h0; bus.preset_1 = 4'h0; bus.limit_0 = 4'h0; bus.limit_1 = 4'h0;

    //            mode  p1    p0    l1    l0    data   n   fin
    tbl[0] = '{1'b0, 4'h0, 4'h3, 4'h0, 4'h0, 8'h03, 3,  8'h00};
    tbl[1] = '{1'b1, 4'h0, 4'h0, 4'h1, 4'h2, 8'h00, 12, 8'h12};
    tbl[2] = '{1'b0, 4'h0, 4'h0, 4'h5, 4'h5, 8'h00, 0,  8'h00};
    tbl[3] = '{1'b1, 4'h4, 4'h4, 4'h0, 4'h0, 8'h00, 0,  8'h00};
    tbl[4] = '{1'b0, 4'hC, 4'hF, 4'h0, 4'h0, 8'h99, 99, 8'h00};
    tbl[5] = '{1'b0, 4'h2, 4'h1, 4'h0, 4'h0, 8'h21, 21, 8'h00};
    tbl[6] = '{1'b1, 4'h7, 4'h7, 4'h0, 4'h5, 8'h00, 5,  8'h05};
    tbl[7] = '{1'b0, 4'h0, 4'hB, 4'h0, 4'h0, 8'h09, 9,  8'h00};

    // Reset state
    #12;
    check("rst state", bus.state, 0);
    check("rst ctr_reset", bus.ctr_reset, 1);
    check("rst ctr_load", bus.ctr_load, 0);
    check("rst ctr_on", bus.ctr_on, 0);
    check("rst busy/done", {bus.busy, bus.done}, 0);
    check("rst count_up", bus.ctr_count_up, 0);
    check("rst ctr_data", {bus.ctr_data_1, bus.ctr_data_0}, 0);
    @(negedge clk); reset = 1'b0; #1;
    check("ctr_reset released", bus.ctr_reset, 0);

    for (int i = 0; i < NV; i++) run_vec(tbl[i], i);

    // Pause for 10 cycles after the second tick of a 05 countdown
    do_clear();
    issue_start(1'b0, 4'h0, 4'h5, 4'h0, 4'h0, t0);
    exp_on.push_back(t0 + 5);  exp_on.push_back(t0 + 9);
    exp_on.push_back(t0 + 24); exp_on.push_back(t0 + 28); exp_on.push_back(t0 + 32);
    wait_cyc(t0 + 10); bus.pause = 1'b1;
    wait_cyc(t0 + 11); #1;
    check("paused state", bus.state, 3);
    check("paused busy", bus.busy, 1);
    wait_cyc(t0 + 20); bus.pause = 1'b0; bus.start = 1'b1; #1;
    check("still paused", bus.state, 3);
    wait_cyc(t0 + 21); bus.start = 1'b0; #1;
    check("resumed state", bus.state, 2);
    wait_done(t0 + 60, at);
    check("pause done cycle", at, t0 + 34);
    check("pause ticks left", exp_on.size(), 0);

    // clear + pause + start together on a tick cycle
    do_clear();
    issue_start(1'b0, 4'h0, 4'h5, 4'h0, 4'h0, t0);
    wait_cyc(t0 + 5);
    bus.clear = 1'b1; bus.pause = 1'b1; bus.start = 1'b1; #1;
    check("prio ctr_reset", bus.ctr_reset, 1);
    check("prio ctr_on", bus.ctr_on, 0);
    wait_cyc(t0 + 6);
    bus.clear = 1'b0; bus.pause = 1'b0; bus.start = 1'b0; #1;
    check("prio state", bus.state, 0);
    check("prio ctr_reset one cycle", bus.ctr_reset, 0);
    check("prio cnt cleared", cnt, 8'h00);

    // Non-BCD limit digit: counter wraps 99 -> 00 and keeps running
    issue_start(1'b1, 4'h0, 4'h0, 4'h0, 4'hA, t0);
    for (int k = 1; k <= 110; k++) exp_on.push_back(t0 + 1 + 4 * k);
    wait_cyc(t0 + 443); #1;
    check("wrap state", bus.state, 2);
    check("wrap cnt", cnt, 8'h10);
    do_clear();
    check("wrap ticks left", exp_on.size(), 0);

    // Asynchronous reset in the middle of a run
    do_clear();
    issue_start(1'b0, 4'h3, 4'h7, 4'h0, 4'h0, t0);
    exp_on.push_back(t0 + 5);
    wait_cyc(t0 + 7); #3; reset = 1'b1; #1;
    check("mid rst state", bus.state, 0);
    check("mid rst ctr_reset", bus.ctr_reset, 1);
    check("mid rst ctr_data", {bus.ctr_data_1, bus.ctr_data_0}, 0);
    check("mid rst busy/done/load/on", {bus.busy, bus.done, bus.ctr_load, bus.ctr_on}, 0);
    @(negedge clk); reset = 1'b0;
    check("mid rst ticks left", exp_on.size(), 0);

    do_clear();
    issue_start(1'b0, 4'h0, 4'h2, 4'h0, 4'h0, t0);
`ifdef BCD_TIMER_AUTORELOAD_EN
    exp_on.push_back(t0 + 5);  exp_on.push_back(t0 + 9);
    exp_on.push_back(t0 + 16); exp_on.push_back(t0 + 20);
    wait_cyc(t0 + 11); #1;
    check("ar done pulse", bus.done, 1);
    wait_cyc(t0 + 12); #1;
    check("ar done drop", bus.done, 0);
    check("ar reload", {bus.ctr_load, bus.ctr_data_1, bus.ctr_data_0}, 9'h102);
    wait_cyc(t0 + 22); #1;
    check("ar second done", bus.done, 1);
    wait_cyc(t0 + 23); #1;
    check("ar second reload", {bus.done, bus.ctr_load}, 2'b01);
    do_clear();
    check("ar ticks left", exp_on.size(), 0);
`else
    exp_on.push_back(t0 + 5); exp_on.push_back(t0 + 9);
    wait_done(t0 + 40, at);
    check("hold done cycle", at, t0 + 11);
    wait_cyc(t0 + 16); #1;
    check("done held", {bus.done, bus.state}, {1'b1, 3'd4});
    issue_start(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, t0);
    exp_on.push_back(t0 + 5);
    #1;
    check("restart load", {bus.ctr_load, bus.ctr_data_1, bus.ctr_data_0}, 9'h101);
    wait_done(t0 + 40, at);
    check("restart done cycle", at, t0 + 7);
    check("restart ticks left", exp_on.size(), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish by cycle %0d expected earlier", cyc);
    $fatal(1, "timeout");
  end
endmodule
